// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle synchronous memory reads, fetch FIFO to decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [31:0]           fetch_count,
    output logic [31:0]           flush_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_MASK     = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = RESET_PC & PC_MASK;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflightPc;
    logic [DATA_WIDTH-1:0] r_fifoData [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifoPc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [OCC_W-1:0]      r_occ;

    logic                  w_redirect;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [OCC_W:0]        w_load;

    assign w_redirect = redirect_valid && (r_state != BOOT);
    assign w_pop      = instr_valid && instr_ready;
    // A read returning in the redirect cycle is the only one that can be stale.
    assign w_push     = r_inflight && !w_redirect;
    assign w_load     = ({1'b0, r_occ} + (OCC_W+1)'(r_inflight)) - (OCC_W+1)'(w_pop);

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        case (r_state)
            BOOT:    w_nextState = RUN;
            RUN: begin
                if (halt_req) begin
                    w_nextState = DRAIN;
                end else if (!w_redirect && (w_load < (OCC_W+1)'(FIFO_DEPTH))) begin
                    w_issue = 1'b1;
                end
            end
            DRAIN:   if (!r_inflight) w_nextState = HALTED;
            HALTED:  if (!halt_req) w_nextState = RUN;
            default: w_nextState = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC_AL;
            r_inflight   <= 1'b0;
            r_inflightPc <= '0;
        end else begin
            r_state    <= w_nextState;
            r_inflight <= w_issue;
            if (w_redirect) begin
                r_pc <= redirect_pc & PC_MASK;
            end else if (w_issue) begin
                r_pc         <= r_pc + ADDR_WIDTH'(4);
                r_inflightPc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifoData[i] <= '0;
                r_fifoPc[i]   <= '0;
            end
        end else if (w_redirect) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_push) begin
                r_fifoData[r_wrPtr] <= mem_data;
                r_fifoPc[r_wrPtr]   <= r_inflightPc;
                r_wrPtr             <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    assign mem_rd_en   = w_issue;
    assign mem_addr    = r_pc;
    assign instr_valid = (r_occ != '0);
    assign instr_data  = r_fifoData[r_rdPtr];
    assign instr_pc    = r_fifoPc[r_rdPtr];
    // DRAIN with nothing outstanding is already quiescent, so report it as halted.
    assign halted      = (r_state == HALTED) || ((r_state == DRAIN) && !r_inflight);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetchCount;
    logic [31:0] r_flushCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetchCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (w_pop)      r_fetchCount <= r_fetchCount + 32'd1;
            if (w_redirect) r_flushCount <= r_flushCount + 32'd1;
        end
    end

    assign fetch_count = r_fetchCount;
    assign flush_count = r_flushCount;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model plus PC/word scoreboard.
// Counter expectations follow FETCH_PERF_CNT_EN when it is defined.
module tb_instr_fetch_unit;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic          clk;
    logic          rst;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt_req;
    logic          halted;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic [31:0]   fetch_count;
    logic [31:0]   flush_count;

    entry_t      sb[$];
    entry_t      sbEntry;
    logic [31:0] expPc;
    logic [31:0] lastIssueAddr;
    logic        sawWrap;
    int          issueCount;
    int          tbPops;
    int          tbRedirects;
    int          checkCount;
    int          errorCount;

    instr_fetch_unit #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC  (RPC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .halted        (halted),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .fetch_count   (fetch_count),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous-read instruction memory with address-derived contents.
    initial mem_data = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= memWord(mem_addr);
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard: issues push the expected word, decode accepts pop it, redirects flush it.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            expPc       = RPC;
            tbPops      = 0;
            tbRedirects = 0;
        end else begin
            if (instr_valid) begin
                checkOutput("sbNonEmpty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    checkOutput("instrPc", 64'(instr_pc), 64'(sb[0].pc));
                    checkOutput("instrData", 64'(instr_data), 64'(sb[0].data));
                    if (instr_ready) void'(sb.pop_front());
                end
                if (instr_ready) tbPops++;
            end
            if (mem_rd_en) begin
                checkOutput("issueAddr", 64'(mem_addr), 64'(expPc));
                if (lastIssueAddr == 32'hFFFF_FFFC && mem_addr == 32'h0) sawWrap = 1'b1;
                lastIssueAddr = mem_addr;
                sbEntry.pc    = expPc;
                sbEntry.data  = memWord(expPc);
                sb.push_back(sbEntry);
                expPc = expPc + 32'd4;
                issueCount++;
            end
            if (halt_req || halted) checkOutput("noIssueWhileHalt", 64'(mem_rd_en), 64'd0);
            if (redirect_valid) begin
                checkOutput("noIssueOnRedirect", 64'(mem_rd_en), 64'd0);
                sb.delete();
                expPc = redirect_pc & ~32'h3;
                tbRedirects++;
            end
        end
    end

    task automatic applyStimulus(input logic redir, input logic [31:0] target, input logic halt, input logic ready);
        @(posedge clk);
        #1;
        redirect_valid = redir;
        redirect_pc    = target;
        halt_req       = halt;
        instr_ready    = ready;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstMemRdEn", 64'(mem_rd_en), 64'd0);
        checkOutput("rstMemAddr", 64'(mem_addr), 64'(RPC));
        checkOutput("rstValid", 64'(instr_valid), 64'd0);
        checkOutput("rstData", 64'(instr_data), 64'd0);
        checkOutput("rstPc", 64'(instr_pc), 64'd0);
        checkOutput("rstHalted", 64'(halted), 64'd0);
        checkOutput("rstFetchCount", 64'(fetch_count), 64'd0);
        checkOutput("rstFlushCount", 64'(flush_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  lat;
        int  cnt;
        int  base;
        logic found;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        instr_ready    = 1'b1;
        sawWrap        = 1'b0;
        lastIssueAddr  = '0;
        issueCount     = 0;
        checkCount     = 0;
        errorCount     = 0;
        expPc          = RPC;

        // Reset, then first word three cycles after release and one per cycle after that.
        applyReset();
        lat   = 99;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
                lat   = i;
            end
        end
        checkOutput("firstValidLatency", 64'(lat), 64'd3);
        checkOutput("firstPc", 64'(instr_pc), 64'(RPC));
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (instr_valid) cnt++;
        end
        checkOutput("throughput", 64'(cnt), 64'd8);

        // Mid-run reset with decode stalled: only FIFO_DEPTH issues may happen.
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyReset();
        base = issueCount;
        repeat (12) @(negedge clk);
        checkOutput("stallIssues", 64'(issueCount - base), 64'(DEPTH));
        checkOutput("stallValid", 64'(instr_valid), 64'd1);
        checkOutput("stallPc", 64'(instr_pc), 64'(RPC));
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("resumeSameCycle", 64'(mem_rd_en), 64'd1);

        // Redirect to an unaligned target while streaming.
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h203, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("validDropAfterRedirect", 64'(instr_valid), 64'd0);
        checkOutput("redirectIssue", 64'(mem_rd_en), 64'd1);
        checkOutput("redirectAddr", 64'(mem_addr), 64'h200);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("redirectWordValid", 64'(instr_valid), 64'd1);
        checkOutput("redirectWordPc", 64'(instr_pc), 64'h200);

        // Halt while streaming, drain, then resume at the next sequential PC.
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
        checkOutput("haltReached", 64'(found), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("drained", 64'(instr_valid), 64'd0);
        checkOutput("haltHeld", 64'(halted), 64'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("haltReleased", 64'(halted), 64'd0);
        checkOutput("resumeIssue", 64'(mem_rd_en), 64'd1);

        // PC wrap through the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checkOutput("pcWrap", 64'(sawWrap), 64'd1);

        // Counters since the last reset.
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("fetchCount", 64'(fetch_count), 64'(tbPops));
        checkOutput("flushCount", 64'(flush_count), 64'(tbRedirects));
`else
        checkOutput("fetchCount", 64'(fetch_count), 64'd0);
        checkOutput("flushCount", 64'(flush_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
